// File: rtl/page_program_buffer.sv
// page_program_buffer: packs page-program bytes into 16-byte masked writes with page wrap and req/ack handoff.
module page_program_buffer #(
  parameter int PAGE_BITS = 8,
  parameter int ADDR_W = 18
) (
  input  logic              sck,
  input  logic              rst,
  input  logic              prog_start,
  input  logic [31:0]       addr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic              prog_end,
  input  logic              mem_wr_ack,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [127:0]      mem_wr_data,
  output logic [15:0]       mem_wr_mask,
  output logic              busy,
  output logic              overflow,
  output logic              done
);
  localparam int PB_W = ADDR_W + 4 - PAGE_BITS;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t state, state_next;
  logic [PB_W-1:0] page_base;
  logic [PAGE_BITS-1:0] byte_ptr;
  logic [127:0] cbuf, nbuf;
  logic [15:0] cmask, nmask;
  logic [ADDR_W-1:0] caddr, cur_addr, hand_addr;
  logic hold_pending, accept, full_now, handoff, start, unused;
  assign unused = ^addr[31:ADDR_W+4];
  assign start = state == IDLE && prog_start;
  assign cur_addr = {page_base, byte_ptr[PAGE_BITS-1:4]};
  assign accept = state == COLLECT && byte_valid && !hold_pending;
  assign full_now = accept && byte_ptr[3:0] == 4'hF;
  // A completed packet goes straight out if the write stage frees up this cycle; otherwise it parks in hold.
  assign handoff = (full_now || hold_pending || (state == DRAIN && cmask != 16'h0)) && (!mem_wr_req || mem_wr_ack);
  assign hand_addr = full_now ? cur_addr : caddr;
  always_comb begin
    nbuf = cbuf;
    nmask = cmask;
    if (accept) begin
      nbuf[{byte_ptr[3:0], 3'b000} +: 8] = byte_in;
      nmask[byte_ptr[3:0]] = 1'b1;
    end
  end
  always_comb begin
    done = state == DRAIN && cmask == 16'h0 && !mem_wr_req;
    busy = state != IDLE;
    state_next = start ? COLLECT :
                 (state == COLLECT && prog_end) ? DRAIN :
                 done ? IDLE : state;
  end
  always_ff @(posedge sck) begin
    if (rst) begin
      state <= IDLE;
      page_base <= '0;
      byte_ptr <= '0;
      cbuf <= '1;
      cmask <= '0;
      caddr <= '0;
      hold_pending <= 1'b0;
      overflow <= 1'b0;
      mem_wr_req <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '1;
      mem_wr_mask <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        page_base <= addr[ADDR_W+3:PAGE_BITS];
        byte_ptr <= addr[PAGE_BITS-1:0];
        overflow <= 1'b0;
      end
      if (accept) begin
        byte_ptr <= byte_ptr + 1'b1;
        caddr <= cur_addr;
      end
      if (state == COLLECT && byte_valid && hold_pending) overflow <= 1'b1;
      if (handoff) begin
        mem_wr_req <= 1'b1;
        mem_wr_addr <= hand_addr;
        mem_wr_data <= nbuf;
        mem_wr_mask <= nmask;
      end else if (mem_wr_ack) mem_wr_req <= 1'b0;
      if (handoff || start) begin
        cbuf <= '1;
        cmask <= '0;
        hold_pending <= 1'b0;
      end else begin
        cbuf <= nbuf;
        cmask <= nmask;
        if (full_now) hold_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_page_program_buffer.sv
// tb_page_program_buffer: directed stimulus with a write scoreboard checked by an independent monitor.
module tb_page_program_buffer;
  logic sck = 0, rst = 1, prog_start = 0, byte_valid = 0, prog_end = 0, ack = 0;
  logic [31:0] addr = 0;
  logic [7:0] byte_in = 0;
  logic mem_wr_req, busy, overflow, done;
  logic [17:0] mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic [15:0] mem_wr_mask;
  typedef struct packed {logic [17:0] a; logic [15:0] m; logic [127:0] d;} wr_t;
  wr_t q[$];
  wr_t e_m;
  int checks = 0, passes = 0, cyc = 0, last_ack_cyc = 0, done_cnt = 0, req_rise = 0;
  int ack_dly = 2, wait_cnt = 0;
  logic ack_en = 0, prev_req = 0;

  page_program_buffer dut (
    .sck(sck), .rst(rst), .prog_start(prog_start), .addr(addr), .byte_valid(byte_valid),
    .byte_in(byte_in), .prog_end(prog_end), .mem_wr_ack(ack), .mem_wr_req(mem_wr_req),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
    .busy(busy), .overflow(overflow), .done(done)
  );

  initial forever #5 sck = ~sck;
  always @(posedge sck) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  always @(posedge sck) begin
    #1;
    if (ack_en) begin
      if (mem_wr_req && !ack) begin
        if (wait_cnt >= ack_dly) begin ack = 1; wait_cnt = 0; end
        else wait_cnt++;
      end else begin
        ack = 0;
        wait_cnt = 0;
      end
    end
  end

  always @(negedge sck) begin
    if (!rst && mem_wr_req && ack) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %h mask %h, required no write", mem_wr_addr, mem_wr_mask);
      end else begin
        e_m = q.pop_front();
        chk("wr_addr", mem_wr_addr, e_m.a);
        chk("wr_mask", mem_wr_mask, e_m.m);
        chk("wr_data", mem_wr_data, e_m.d);
      end
      last_ack_cyc = cyc;
    end
    if (done) done_cnt++;
    if (mem_wr_req && !prev_req) req_rise++;
    prev_req = mem_wr_req;
  end

  task automatic tick;
    @(posedge sck);
    #1;
  endtask

  task automatic start_seq(input logic [31:0] a);
    prog_start = 1; addr = a;
    tick();
    prog_start = 0;
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1; byte_in = b;
    tick();
    byte_valid = 0;
  endtask

  task automatic end_seq(output int c);
    prog_end = 1; c = cyc;
    tick();
    prog_end = 0;
  endtask

  task automatic wait_done(input string name, input bit after_ack, input int end_c);
    int exp_c;
    for (int i = 0; i < 400; i++) begin
      @(negedge sck);
      if (done) break;
    end
    exp_c = after_ack ? last_ack_cyc + 1 : end_c + 1;
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_done_cycle"}, cyc, exp_c);
    @(negedge sck);
    chk({name, "_done_pulse"}, done, 1'b0);
    chk({name, "_busy_idle"}, busy, 1'b0);
    chk({name, "_queue_empty"}, q.size(), 0);
  endtask

  initial begin
    wr_t w;
    int ec, dc, rr;
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    wr_t w;
    int ec, dc, rr;
    repeat (3) tick();
    @(negedge sck);
    chk("rst_req", mem_wr_req, 1'b0);
    chk("rst_addr", mem_wr_addr, 18'h0);
    chk("rst_data", mem_wr_data, {128{1'b1}});
    chk("rst_mask", mem_wr_mask, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_done", done, 1'b0);
    tick();
    rst = 0;
    ack_en = 1; ack_dly = 2;
    // offset start, two partial packets
    w.a = 18'h12; w.m = 16'hFFF8; w.d = '1;
    for (int k = 3; k < 16; k++) w.d[k*8 +: 8] = 8'(k - 3);
    q.push_back(w);
    w.a = 18'h13; w.m = 16'h0007; w.d = '1;
    for (int k = 0; k < 3; k++) w.d[k*8 +: 8] = 8'(k + 13);
    q.push_back(w);
    start_seq(32'h123);
    for (int i = 0; i < 16; i++) send(8'(i));
    end_seq(ec);
    wait_done("t1", 1, ec);
    // page wrap stays inside the page
    tick();
    w.a = 18'h1F; w.m = 16'hFF00; w.d = '1;
    for (int k = 8; k < 16; k++) w.d[k*8 +: 8] = 8'(8'h80 + k - 8);
    q.push_back(w);
    w.a = 18'h10; w.m = 16'h00FF; w.d = '1;
    for (int k = 0; k < 8; k++) w.d[k*8 +: 8] = 8'(8'h88 + k);
    q.push_back(w);
    start_seq(32'h1F8);
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    end_seq(ec);
    wait_done("t2", 1, ec);
    // back-pressure: third packet dropped
    tick();
    ack_dly = 60;
    w.a = 18'h0; w.m = 16'hFFFF;
    for (int k = 0; k < 16; k++) w.d[k*8 +: 8] = 8'(k + 1);
    q.push_back(w);
    w.a = 18'h1;
    for (int k = 0; k < 16; k++) w.d[k*8 +: 8] = 8'(k + 17);
    q.push_back(w);
    start_seq(32'h0);
    for (int i = 1; i <= 48; i++) send(8'(i));
    @(negedge sck);
    chk("t3_overflow", overflow, 1'b1);
    tick();
    end_seq(ec);
    for (int i = 0; i < 200; i++) begin
      @(negedge sck);
      if (mem_wr_req && ack) break;
    end
    @(negedge sck);
    chk("t3_b2b_req", mem_wr_req, 1'b1);
    chk("t3_b2b_addr", mem_wr_addr, 18'h1);
    wait_done("t3", 1, ec);
    chk("t3_overflow_sticky", overflow, 1'b1);
    // empty sequence; also clears overflow
    tick();
    rr = req_rise;
    start_seq(32'h200);
    end_seq(ec);
    wait_done("t4", 0, ec);
    chk("t4_overflow_cleared", overflow, 1'b0);
    chk("t4_no_req", req_rise, rr);
    // reset while a write is outstanding
    tick();
    ack_en = 0; ack = 0;
    start_seq(32'h0);
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
    @(negedge sck);
    chk("t5_req_up", mem_wr_req, 1'b1);
    tick();
    dc = done_cnt;
    rst = 1;
    tick();
    rst = 0;
    @(negedge sck);
    chk("t5_req", mem_wr_req, 1'b0);
    chk("t5_mask", mem_wr_mask, 16'h0);
    chk("t5_data", mem_wr_data, {128{1'b1}});
    chk("t5_busy", busy, 1'b0);
    tick();
    ack = 1;
    tick();
    ack = 0;
    repeat (3) @(negedge sck);
    chk("t5_late_ack", mem_wr_req, 1'b0);
    chk("t5_no_done", done_cnt, dc);
    // start during COLLECT ignored, byte with prog_end kept
    tick();
    ack_en = 1; ack_dly = 2;
    w.a = 18'h4; w.m = 16'h000F; w.d = '1;
    w.d[31:0] = 32'hDDCCBBAA;
    q.push_back(w);
    start_seq(32'h40);
    send(8'hAA);
    send(8'hBB);
    prog_start = 1; addr = 32'h500;
    send(8'hCC);
    prog_start = 0;
    byte_valid = 1; byte_in = 8'hDD;
    end_seq(ec);
    byte_valid = 0;
    wait_done("t6", 1, ec);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/page_program_buffer.md
Name: page_program_buffer

Overview:
- Write-direction counterpart of the flash read datapath: collects program-data bytes arriving from the I/O shift buffer during a page-program command.
- Packs bytes into 16-byte packets with byte-enable masks and hands each packet to the memory array as one 128-bit write with an 18-bit packet address.
- Wraps within the programmed page, as flash page program does.
- Two-stage buffering (collect buffer + write stage) with a req/ack handshake toward the array.

Parameters:
- PAGE_BITS, 8, log2 of page size in bytes (256-byte page); minimum 4.
- ADDR_W, 18, packet-address width; packet address = addr[ADDR_W+3:4].

Ports:
- sck  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- prog_start  in  1  one-cycle pulse; starts a program sequence; addr is valid this cycle.
- addr  in  32  start byte address.
- byte_valid  in  1  byte_in holds a new data byte this cycle.
- byte_in  in  8  program data byte.
- prog_end  in  1  one-cycle pulse at CS# rise; ends the sequence.
- mem_wr_ack  in  1  array accepted the current write.
- mem_wr_req  out  1  write request; held until ack.
- mem_wr_addr  out  ADDR_W  16-byte packet address.
- mem_wr_data  out  128  byte k = bits [8k+7:8k].
- mem_wr_mask  out  16  bit k = byte k valid.
- busy  out  1  high whenever state != IDLE.
- overflow  out  1  sticky; a byte was dropped.
- done  out  1  one-cycle pulse; sequence complete.

Behaviour:
Reset (rst high at an edge):
- state=IDLE; mem_wr_req=0, mem_wr_addr=0, mem_wr_data=all ones, mem_wr_mask=0, busy=0, overflow=0, done=0.
- Collect buffer bytes=8'hFF, mask=0, hold_pending=0.
- Reset mid-operation abandons all data; an ack arriving after reset is ignored.

States:
- IDLE
  - prog_start -> COLLECT.
  - Latch page_base = addr[ADDR_W+3:PAGE_BITS] and byte_ptr = addr[PAGE_BITS-1:0].
  - Clear overflow. Collect buffer reset to FF/mask 0.
- COLLECT
  - Accepting byte_valid (with hold_pending=0):
    - buf[byte_ptr[3:0]] <= byte_in; mask bit set.
    - byte_ptr <= byte_ptr+1, mod 2^PAGE_BITS. Page wrap 255->0 stays in the same page.
    - A byte rewritten at the same offset before handoff: last value wins.
  - Byte written at offset 15 completes the packet and triggers a handoff. Packet address = {page_base, byte_ptr[PAGE_BITS-1:4]} captured at that byte.
  - byte_valid while hold_pending=1: byte dropped, overflow <= 1.
  - prog_end -> DRAIN. A byte_valid in the same cycle is accepted first.
- DRAIN
  - If collect mask != 0, hand it off (partial packet) when the write stage is free.
  - When collect is empty and the write stage is empty: done=1 for one cycle, then IDLE.
  - byte_valid ignored.
- prog_start outside IDLE: ignored.

Handoff and write stage:
- The write stage is free if mem_wr_req=0, or mem_wr_req=1 with mem_wr_ack=1 this cycle.
- If free: next cycle mem_wr_req=1 with addr/data/mask loaded; collect resets to FF/mask 0.
  - An ack in the same cycle gives back-to-back requests with no req low cycle.
- If not free: hold_pending=1; handoff occurs in the first cycle the stage becomes free.
- While mem_wr_req=1 and ack=0: addr/data/mask stay stable.
- Ack with nothing pending: req=0 next cycle; data/addr/mask keep their last values.
- Unmasked data bytes are always 8'hFF (erased value), so AND-programming is harmless.
- mem_wr_ack while req=0: ignored.

Latency:
- First request: the cycle after the byte completing the packet.
- done:
  - the cycle after the final ack is sampled;
  - or, with nothing to write, the cycle after prog_end.

Test Plan:
1. Offset start, partial packets:
   - Stimulus: prog_start addr=0x000123; bytes 0x00..0x0F; ack 2 cycles after each req; prog_end.
   - Response: write addr=0x00012, mask=0xFFF8, bytes 3..15 = 0x00..0x0C, bytes 0..2 = FF.
   - Then addr=0x00013, mask=0x0007, bytes 0..2 = 0x0D..0x0F.
   - done one cycle after the second ack; busy=0.
2. Page wrap:
   - Stimulus: addr=0x0001F8, 16 bytes, then prog_end.
   - Response: addr=0x0001F mask=0xFF00, then addr=0x00010 (not 0x00020) mask=0x00FF.
3. Back-pressure:
   - Stimulus: addr=0x000000, 48 bytes back-to-back, ack low for 60 cycles then pulsed.
   - Response: packets 0x00000 and 0x00001 written with mask 0xFFFF, back-to-back req.
   - Bytes 33..48 dropped; overflow=1 until the next prog_start; no third write.
4. Empty sequence:
   - Stimulus: prog_start then prog_end with no bytes.
   - Response: mem_wr_req never rises; done pulses the cycle after prog_end.
5. Reset mid-write:
   - Stimulus: rst=1 while req=1 and ack=0; ack pulsed afterwards.
   - Response: next cycle req=0, mask=0, data=all ones, busy=0; no done; late ack has no effect.
6. Busy-time start and simultaneous end:
   - Stimulus: prog_start during COLLECT; byte in the same cycle as prog_end.
   - Response: start ignored (page_base unchanged); the simultaneous byte appears in the final packet mask.
